// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing one VGA pixel-write port among N_REQ drawing engines,
// with a built-in full-screen clear engine that pre-empts every requester.
module vga_plot_arbiter #(
    parameter int N_REQ    = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_x,
    input  logic [7*N_REQ-1:0] req_y,
    input  logic [3*N_REQ-1:0] req_colour,
    output logic [N_REQ-1:0]   gnt,
    input  logic               clear_start,
    input  logic [2:0]         clear_colour,
    output logic               clear_busy,
    output logic               clear_done,
    output logic [7:0]         vga_x,
    output logic [6:0]         vga_y,
    output logic [2:0]         vga_colour,
    output logic               vga_plot
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {ARB, CLEAR} state_t;

    state_t        state, state_next;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;
    logic          gnt_valid;
    logic [PW:0]   cand;
    logic [7:0]    cnt_x;
    logic [6:0]    cnt_y;
    logic [2:0]    fill_colour;
    logic [7:0]    sel_x;
    logic [6:0]    sel_y;
    logic [2:0]    sel_colour;
    logic          sel_visible;
    logic          last_pixel;

    assign last_pixel  = (cnt_x == 8'(SCREEN_W - 1)) && (cnt_y == 7'(SCREEN_H - 1));
    assign sel_x       = req_x[int'(gnt_idx) * 8 +: 8];
    assign sel_y       = req_y[int'(gnt_idx) * 7 +: 7];
    assign sel_colour  = req_colour[int'(gnt_idx) * 3 +: 3];
    assign sel_visible = (int'(sel_x) < SCREEN_W) && (int'(sel_y) < SCREEN_H);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    // Requests are searched from the slot after the last winner; a clear request blocks all grants.
    always_comb begin
        state_next = state;
        gnt        = '0;
        gnt_idx    = '0;
        gnt_valid  = 1'b0;
        cand       = '0;
        case (state)
            ARB: begin
                if (clear_start) begin
                    state_next = CLEAR;
                end else begin
                    for (int k = 1; k <= N_REQ; k++) begin
                        cand = {1'b0, ptr} + (PW+1)'(k);
                        if (cand >= (PW+1)'(N_REQ)) begin
                            cand = cand - (PW+1)'(N_REQ);
                        end
                        if (!gnt_valid && req[cand[PW-1:0]]) begin
                            gnt_valid = 1'b1;
                            gnt_idx   = cand[PW-1:0];
                        end
                    end
                    if (gnt_valid) begin
                        gnt[gnt_idx] = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (last_pixel) begin
                    state_next = ARB;
                end
            end
            default: state_next = ARB;
        endcase
    end

    // The clear counters track the pixel currently on the outputs, so (0,0) is loaded on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= PW'(N_REQ - 1);
            cnt_x       <= '0;
            cnt_y       <= '0;
            fill_colour <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
            clear_busy  <= 1'b0;
            clear_done  <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                ARB: begin
                    if (clear_start) begin
                        fill_colour <= clear_colour;
                        cnt_x       <= '0;
                        cnt_y       <= '0;
                        vga_x       <= '0;
                        vga_y       <= '0;
                        vga_colour  <= clear_colour;
                        vga_plot    <= 1'b1;
                        clear_busy  <= 1'b1;
                    end else if (gnt_valid) begin
                        ptr        <= gnt_idx;
                        vga_x      <= sel_x;
                        vga_y      <= sel_y;
                        vga_colour <= sel_colour;
                        vga_plot   <= sel_visible;
                    end else begin
                        vga_plot <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (last_pixel) begin
                        vga_plot   <= 1'b0;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        if (cnt_x == 8'(SCREEN_W - 1)) begin
                            cnt_x <= '0;
                            cnt_y <= cnt_y + 7'd1;
                            vga_x <= '0;
                            vga_y <= cnt_y + 7'd1;
                        end else begin
                            cnt_x <= cnt_x + 8'd1;
                            vga_x <= cnt_x + 8'd1;
                        end
                        vga_colour <= fill_colour;
                        vga_plot   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: directed scenarios plus random traffic,
// all compared cycle by cycle against a pixel-index level reference model.
module tb_vga_plot_arbiter;

    localparam int N = 4;
    localparam int W = 160;
    localparam int H = 120;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_x;
    logic [7*N-1:0] req_y;
    logic [3*N-1:0] req_colour;
    logic [N-1:0]   gnt;
    logic           clear_start;
    logic [2:0]     clear_colour;
    logic           clear_busy;
    logic           clear_done;
    logic [7:0]     vga_x;
    logic [6:0]     vga_y;
    logic [2:0]     vga_colour;
    logic           vga_plot;

    int checks = 0;
    int errors = 0;

    // Reference model: requester pointer, clear progress as a linear pixel index, expected registers.
    int         m_ptr;
    bit         m_clear;
    int         m_pix;
    logic [2:0] m_fill;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_c;
    logic       e_plot, e_busy, e_done;
    logic [N-1:0] last_gnt;

    int plot_count;
    int done_count;

    vga_plot_arbiter #(.N_REQ(N), .SCREEN_W(W), .SCREEN_H(H)) dut (
        .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
        .req_colour(req_colour), .gnt(gnt), .clear_start(clear_start),
        .clear_colour(clear_colour), .clear_busy(clear_busy), .clear_done(clear_done),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_ptr   = N - 1;
        m_clear = 0;
        m_pix   = 0;
        m_fill  = '0;
        e_x = '0; e_y = '0; e_c = '0;
        e_plot = 0; e_busy = 0; e_done = 0;
    endtask

    function automatic logic [N-1:0] modelGnt(input logic [N-1:0] r, input logic cst);
        logic [N-1:0] g = '0;
        if (!m_clear && !cst) begin
            for (int k = 1; k <= N; k++) begin
                int i = (m_ptr + k) % N;
                if (r[i] && g == '0) g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic modelEdge(input logic [N-1:0] g);
        e_done = 0;
        if (m_clear) begin
            if (m_pix == W*H - 1) begin
                m_clear = 0;
                e_plot  = 0;
                e_busy  = 0;
                e_done  = 1;
            end else begin
                m_pix++;
                e_x    = 8'(m_pix % W);
                e_y    = 7'(m_pix / W);
                e_c    = m_fill;
                e_plot = 1;
            end
        end else if (clear_start) begin
            m_clear = 1;
            m_pix   = 0;
            m_fill  = clear_colour;
            e_x = '0; e_y = '0; e_c = clear_colour;
            e_plot = 1;
            e_busy = 1;
        end else if (g != '0) begin
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    m_ptr = i;
                    e_x = req_x[8*i +: 8];
                    e_y = req_y[7*i +: 7];
                    e_c = req_colour[3*i +: 3];
                    e_plot = (int'(e_x) < W) && (int'(e_y) < H);
                end
            end
        end else begin
            e_plot = 0;
        end
    endtask

    // One clock cycle: drive inputs, compare everything at the falling edge, advance the model.
    task automatic applyStimulus(input logic [N-1:0] r, input logic [8*N-1:0] xs,
                                 input logic [7*N-1:0] ys, input logic [3*N-1:0] cs,
                                 input logic cst, input logic [2:0] ccol);
        logic [N-1:0] g;
        req = r; req_x = xs; req_y = ys; req_colour = cs;
        clear_start = cst; clear_colour = ccol;
        @(negedge clk);
        g = modelGnt(r, cst);
        checkOutput("gnt", 32'(gnt), 32'(g));
        checkOutput("vga_plot", 32'(vga_plot), 32'(e_plot));
        checkOutput("vga_x", 32'(vga_x), 32'(e_x));
        checkOutput("vga_y", 32'(vga_y), 32'(e_y));
        checkOutput("vga_colour", 32'(vga_colour), 32'(e_c));
        checkOutput("clear_busy", 32'(clear_busy), 32'(e_busy));
        checkOutput("clear_done", 32'(clear_done), 32'(e_done));
        if (vga_plot) plot_count++;
        if (clear_done) done_count++;
        last_gnt = g;
        modelEdge(g);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8*N-1:0] packX(input int i, input int v);
        logic [8*N-1:0] p = '0;
        logic [7:0] b = 8'(v);
        p[8*i +: 8] = b;
        return p;
    endfunction

    function automatic logic [7*N-1:0] packY(input int i, input int v);
        logic [7*N-1:0] p = '0;
        logic [6:0] b = 7'(v);
        p[7*i +: 7] = b;
        return p;
    endfunction

    function automatic logic [3*N-1:0] packC(input int i, input int v);
        logic [3*N-1:0] p = '0;
        logic [2:0] b = 3'(v);
        p[3*i +: 3] = b;
        return p;
    endfunction

    task automatic checkAsyncReset(input string tag);
        checkOutput({tag, " vga_x"}, 32'(vga_x), 32'd0);
        checkOutput({tag, " vga_y"}, 32'(vga_y), 32'd0);
        checkOutput({tag, " vga_colour"}, 32'(vga_colour), 32'd0);
        checkOutput({tag, " vga_plot"}, 32'(vga_plot), 32'd0);
        checkOutput({tag, " clear_busy"}, 32'(clear_busy), 32'd0);
        checkOutput({tag, " clear_done"}, 32'(clear_done), 32'd0);
    endtask

    // Full clear with an optional re-trigger mid-fill; checks plot total and the single done pulse.
    task automatic runClear(input string tag, input logic [N-1:0] r, input logic [2:0] col,
                            input int repulse_at);
        logic [8*N-1:0] xs = '0;
        logic [7*N-1:0] ys = '0;
        logic [3*N-1:0] cs = '0;
        for (int i = 0; i < N; i++) begin
            xs |= packX(i, 20 + i);
            ys |= packY(i, 30 + i);
            cs |= packC(i, i + 1);
        end
        applyStimulus(r, xs, ys, cs, 1'b1, col);
        plot_count = 0;
        done_count = 0;
        for (int n = 0; n <= W*H; n++) begin
            if (n == repulse_at) applyStimulus(r, xs, ys, cs, 1'b1, 3'b111);
            else if (repulse_at >= 0 && n > repulse_at) applyStimulus(r, xs, ys, cs, 1'b0, 3'b111);
            else applyStimulus(r, xs, ys, cs, 1'b0, col);
        end
        checkOutput({tag, " plot total"}, 32'(plot_count), 32'(W*H));
        checkOutput({tag, " done pulses"}, 32'(done_count), 32'd1);
        applyStimulus(r, xs, ys, cs, 1'b0, col);
    endtask

    initial begin
        logic [8*N-1:0] xs;
        logic [7*N-1:0] ys;
        logic [3*N-1:0] cs;
        logic [N-1:0]   r;
        bit   [N-1:0]   pend;
        int   px[N], py[N], pc[N];

        rst = 1'b1;
        req = '0; req_x = '0; req_y = '0; req_colour = '0;
        clear_start = 1'b0; clear_colour = '0;
        modelReset();
        plot_count = 0;
        done_count = 0;
        #2;
        checkAsyncReset("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] single request");
        applyStimulus(4'b0001, packX(0, 10), packY(0, 20), packC(0, 4), 1'b0, 3'b000);
        applyStimulus(4'b0000, '0, '0, '0, 1'b0, 3'b000);
        applyStimulus(4'b0000, '0, '0, '0, 1'b0, 3'b000);

        $display("[TB] all requesting");
        xs = '0; ys = '0; cs = '0;
        for (int i = 0; i < N; i++) begin
            xs |= packX(i, 10*i + 1);
            ys |= packY(i, i + 2);
            cs |= packC(i, i + 1);
        end
        for (int c = 0; c < 8; c++) applyStimulus(4'b1111, xs, ys, cs, 1'b0, 3'b000);
        applyStimulus(4'b0000, xs, ys, cs, 1'b0, 3'b000);

        $display("[TB] out-of-range and edge coordinates");
        applyStimulus(4'b0100, packX(2, 160), packY(2, 5), packC(2, 6), 1'b0, 3'b000);
        applyStimulus(4'b0100, packX(2, 159), packY(2, 119), packC(2, 3), 1'b0, 3'b000);
        applyStimulus(4'b0100, packX(2, 20), packY(2, 120), packC(2, 5), 1'b0, 3'b000);
        applyStimulus(4'b0000, '0, '0, '0, 1'b0, 3'b000);

        $display("[TB] clear with pending request");
        runClear("clear1", 4'b0010, 3'b000, -1);

        $display("[TB] clear with re-trigger");
        runClear("clear2", 4'b0000, 3'b101, 100);

        $display("[TB] reset mid-clear");
        applyStimulus(4'b0000, '0, '0, '0, 1'b1, 3'b011);
        done_count = 0;
        for (int n = 0; n < 499; n++) applyStimulus(4'b0000, '0, '0, '0, 1'b0, 3'b011);
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkAsyncReset("midclear");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < 3; n++)
            applyStimulus(4'b0001, packX(0, 77), packY(0, 66), packC(0, 2), 1'b0, 3'b000);
        for (int n = 0; n < W*H; n++) applyStimulus(4'b0000, '0, '0, '0, 1'b0, 3'b000);
        checkOutput("midclear no done", 32'(done_count), 32'd0);

        $display("[TB] random traffic");
        pend = '0;
        for (int i = 0; i < N; i++) begin px[i] = 0; py[i] = 0; pc[i] = 0; end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    px[i] = int'($urandom_range(0, 175));
                    py[i] = int'($urandom_range(0, 127));
                    pc[i] = int'($urandom_range(0, 7));
                end
            end
            xs = '0; ys = '0; cs = '0;
            for (int i = 0; i < N; i++) begin
                xs |= packX(i, px[i]);
                ys |= packY(i, py[i]);
                cs |= packC(i, pc[i]);
            end
            r = N'(pend);
            applyStimulus(r, xs, ys, cs, 1'b0, 3'(c));
            pend &= ~last_gnt;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
